// File: rtl/acc_pkg.sv
// Shared definitions for the multi-channel accumulator: operation encoding,
// default widths and a channel-index width helper.
package acc_pkg;

    // Request operation encoding as carried on in_op.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_e;

    localparam int DEF_IN_W   = 13;
    localparam int DEF_ACC_W  = 21;
    localparam int DEF_CH     = 4;
    localparam bit DEF_SIGNED = 1'b1;

    // Channel index width; a single channel still needs one index bit.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/acc_multi_ch_if.sv
// Request/response bus of the multi-channel accumulator.
// The master modport is the requester side, the slave modport the accumulator.
interface acc_multi_ch_if
    import acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CH_W  = ch_width(DEF_CH)
);

    // Request channel
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [CH_W-1:0]  in_ch;
    logic [IN_W-1:0]  A;
    logic [ACC_W-1:0] sum_out;

    // Response channel
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [ACC_W-1:0] Y;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_ch, A, out_ready,
        input  in_ready, sum_out, out_valid, out_ch, Y, out_err
    );

    modport slave (
        input  in_valid, in_op, in_ch, A, out_ready,
        output in_ready, sum_out, out_valid, out_ch, Y, out_err
    );

endinterface

// File: rtl/acc_addsat.sv
// Combinational operand extension, add/subtract, overflow detection and
// result selection for one accumulator.
// Optional macro ACC_SAT_EN: when defined, ADD/SUB results clamp to the
// accumulator range on overflow; otherwise they wrap modulo 2^ACC_W.
module acc_addsat
    import acc_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter bit SIGNED = DEF_SIGNED
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  operand,
    input  op_e              op,
    output logic [ACC_W-1:0] res,
    output logic             ovf
);

    localparam int MSB = ACC_W - 1;

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    logic [ACC_W-1:0] wrap;

    // Operand extension to accumulator width follows the arithmetic mode.
    generate
        if (SIGNED) begin : g_sext
            assign ext = ACC_W'($signed(operand));
        end else begin : g_zext
            assign ext = ACC_W'(operand);
        end
    endgenerate

    // One extra bit carries the unsigned carry-out / borrow.
    assign sum  = {1'b0, acc} + {1'b0, ext};
    assign diff = {1'b0, acc} - {1'b0, ext};

    // Modular result and overflow flag for the selected operation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        wrap = acc;
        ovf  = 1'b0;
        unique case (op)
            OP_ADD: begin
                wrap = sum[ACC_W-1:0];
                ovf  = SIGNED ? ((acc[MSB] == ext[MSB]) && (wrap[MSB] != acc[MSB]))
                              : sum[ACC_W];
            end
            OP_SUB: begin
                wrap = diff[ACC_W-1:0];
                ovf  = SIGNED ? ((acc[MSB] != ext[MSB]) && (wrap[MSB] != acc[MSB]))
                              : diff[ACC_W];
            end
            default: begin
                wrap = acc;
                ovf  = 1'b0;
            end
        endcase
    end

`ifdef ACC_SAT_EN
    logic [ACC_W-1:0] clamp;

    // Clamp value: signed overflow always moves away from the sign of acc;
    // unsigned overflow is a carry on ADD and a borrow on SUB.
    always_comb begin
        clamp = '0;
        if (SIGNED) begin
            clamp = acc[MSB] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            clamp = (op == OP_SUB) ? '0 : '1;
        end
    end
`endif

    // Final result: arithmetic ops take the (possibly clamped) sum, LOAD the
    // extended operand, READ passes the accumulator through.
    always_comb begin
        res = acc;
        unique case (op)
`ifdef ACC_SAT_EN
            OP_ADD, OP_SUB: res = ovf ? clamp : wrap;
`else
            OP_ADD, OP_SUB: res = wrap;
`endif
            OP_LOAD:        res = ext;
            default:        res = acc;
        endcase
    end

endmodule

// File: rtl/acc_multi_ch.sv
// Multi-channel accumulator with a valid/ready request/response bus.
// CH independent accumulators; each accepted request adds, subtracts, loads
// or reads one channel and returns the resulting value one cycle later
// through a one-deep response register.
// Optional macro ACC_SAT_EN (handled in acc_addsat): saturating ADD/SUB.
module acc_multi_ch
    import acc_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CH     = DEF_CH,
    parameter int CH_W   = ch_width(CH),
    parameter bit SIGNED = DEF_SIGNED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          clr,
    acc_multi_ch_if.slave bus,
    output logic [CH-1:0] ovf
);

    logic [1:0]       rst_sync;
    logic             rst_int;

    logic [ACC_W-1:0] acc_q [CH];
    logic [CH-1:0]    ovf_q;

    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [ACC_W-1:0] y_q;
    logic             out_err_q;

    op_e              op;
    logic             ch_ok;
    logic [ACC_W-1:0] cur_acc;
    logic [ACC_W-1:0] res;
    logic             add_ovf;
    logic             accept;
    logic             write_en;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int = rst_sync[1];
    assign op      = op_e'(bus.in_op);

    // Select the addressed accumulator; ch_ok stays 0 for out-of-range indices.
    always_comb begin
        cur_acc = '0;
        ch_ok   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (bus.in_ch == CH_W'(c)) begin
                cur_acc = acc_q[c];
                ch_ok   = 1'b1;
            end
        end
    end

    acc_addsat #(
        .IN_W   (IN_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_addsat (
        .acc     (cur_acc),
        .operand (bus.A),
        .op      (op),
        .res     (res),
        .ovf     (add_ovf)
    );

    assign bus.sum_out  = ch_ok ? res : '0;
    assign bus.in_ready = rst_int & ce & ~clr & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign write_en     = accept & ch_ok & (op != OP_READ);

    // Accumulator and sticky overflow state: clear wins, then the accepted write.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            // NOTE: the accumulator array is architectural state read back by READ, so every entry is reset, not left as an unreset memory.
            for (int c = 0; c < CH; c++) acc_q[c] <= '0;
            ovf_q <= '0;
        end else if (ce) begin
            if (clr) begin
                for (int c = 0; c < CH; c++) acc_q[c] <= '0;
                ovf_q <= '0;
            end else if (write_en) begin
                for (int c = 0; c < CH; c++) begin
                    if (bus.in_ch == CH_W'(c)) begin
                        acc_q[c] <= res;
                        if (add_ovf && (op == OP_ADD || op == OP_SUB)) ovf_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // One-deep response register: loads on accept, drains on out_ready.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            out_err_q   <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= bus.in_ch;
                y_q         <= ch_ok ? res : '0;
                out_err_q   <= ~ch_ok;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.Y         = y_q;
    assign bus.out_err   = out_err_q;
    assign ovf           = ovf_q;

endmodule

// File: doc/acc_multi_ch.md
Name: acc_multi_ch

Overview:
- Parametrised multi-channel accumulator with a valid/ready request/response interface.
- Holds CH independent accumulator registers.
- Per request: add, subtract, load or read one channel; returns the updated value one cycle later.
- Sits between sample producers and downstream filtering/statistics logic, replacing the single-channel, add-only accumulator.

Parameters:
- IN_W, 13, input operand width.
- ACC_W, 21, accumulator width; must be >= IN_W.
- CH, 4, number of channels; must be >= 1.
- CH_W, $clog2(CH) (minimum 1), channel index width.
- SIGNED, 1, 1 = two's-complement operands/accumulators; 0 = unsigned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; 0 = freeze all state.
- clr  in  1  synchronous clear of all accumulators and overflow flags.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 READ.
- in_ch  in  CH_W  target channel.
- A  in  IN_W  operand.
- sum_out  out  ACC_W  combinational preview of the result for the current in_op/in_ch/A.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid & out_ready.
- out_ch  out  CH_W  channel of response.
- Y  out  ACC_W  channel value after the operation.
- out_err  out  1  response refers to an out-of-range channel.
- ovf  out  CH  sticky per-channel overflow flags.

Behaviour:
- Reset (rst=0, asynchronous): all accumulators 0; ovf=0, out_valid=0, Y=0, out_ch=0, out_err=0. Release is synchronised to clk.
- in_ready = ce & ~clr & (~out_valid | out_ready). One-deep response register; throughput 1 request/cycle while out_ready=1.
- Accept at edge N: accumulator, ovf and response registers update at N. out_valid=1 from N, so latency is 1 cycle.
- A is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
- ADD: acc+A.
- SUB: acc-A.
- LOAD: acc=A (extended); ovf unchanged.
- READ: no state change; Y=current acc.
- Overflow, wrap mode:
  - Result is the ACC_W-bit modular value.
  - SIGNED=1: ovf[ch] sets on operands of equal sign (ADD) or differing sign (SUB) where the result sign differs from acc.
  - SIGNED=0: ovf[ch] sets on carry-out (ADD) or borrow (SUB).
  - The flag stays set until clr or reset.
- Response handshake:
  - out_valid clears when out_ready=1 with no new accept in the same cycle.
  - Response fields stay stable while out_valid=1 and out_ready=0.
- Out-of-range channel (in_ch >= CH, possible only when CH is not a power of two):
  - The request is accepted with no state change.
  - Response is Y=0, out_err=1.
  - sum_out=0.
- clr=1 (with ce=1):
  - All accumulators and ovf go to 0 at the edge.
  - No request is accepted (in_ready=0).
  - A pending response is kept and still drains normally.
- ce=0: every register holds, including response drain; in_ready=0. sum_out still tracks its inputs.
- Same-channel back-to-back accepts use the updated value; no hazard and no bubble.
- rst asserted mid-operation: immediate return to reset state; a pending response is discarded.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: ADD/SUB results clamp to the ACC_W range on overflow. SIGNED=1 clamps to max 2^(ACC_W-1)-1 / min -2^(ACC_W-1); SIGNED=0 clamps to 2^ACC_W-1 / 0. ovf still sets.
- Undefined: wrap behaviour as specified above.

Decomposition:
- Package acc_pkg: op encoding constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_READ=2'b11) and default width constants.
- Sub-module acc_addsat: combinational extend/add/sub/saturate plus overflow detect. Parametrised by IN_W, ACC_W, SIGNED. Shared by the sum_out preview and the update path.

Test Plan (defaults: IN_W=13, ACC_W=21, SIGNED=1, CH=4):
- Reset then ADD ch0 A=100, ADD ch0 A=-30, READ ch0 -> Y=100, Y=70, Y=70; latency 1 cycle each; other channels 0.
- Interleave ADD ch1 A=5, ADD ch2 A=7 every cycle with out_ready=1 -> responses in order; ch1=5, ch2=7 with no bubbles.
- Hold out_ready=0 for 3 cycles with a response pending -> in_ready=0 and Y/out_ch stable; release -> next request accepted in the same cycle.
- LOAD ch3 A=4095 and shift via repeated ADD 4095 until past 1048575 -> wrap build: Y wraps negative, ovf[3]=1; ACC_SAT_EN build: Y=1048575, ovf[3]=1.
- clr pulse with a response pending -> response still delivered; afterwards READ on all channels gives 0 and ovf=0.
- Assert rst mid-burst asynchronously -> outputs zero before the next clk edge; first post-reset ADD ch0 A=1 gives Y=1.
